// File: rtl/mrv32_pkg.sv
// Shared constants and types for the mrv32 memory subsystem.
package mrv32_pkg;

  // Port B byte-address width.
  localparam int ADDR_WIDTH = 32;

  // All-zero strobe marks a read.
  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  // Default number of Port B reads allowed in flight.
  localparam int PORTB_ARB_MAX_OUTSTANDING = 2;

  // Port B requester identity, also stored as the read-owner tag.
  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_id_t;

endpackage

// File: rtl/mrv32_tag_fifo.sv
// Small synchronous FIFO holding read-owner tags.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module mrv32_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mrv32_portb_arb.sv
// Port B arbiter: shares the data-memory Port B between the LSU (M0) and the
// debug/loader master (M1). Round-robin grant per request with zero-cycle
// forwarding; read owners are queued in order so responses return to the issuer.
// Optional statistics counters are built when MRV32_PORTB_ARB_STATS_EN is defined.
module mrv32_portb_arb #(
  parameter int ADDR_WIDTH      = mrv32_pkg::ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = mrv32_pkg::PORTB_ARB_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rvalid,
  output logic                  b_valid,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [31:0]           b_wdata,
  output logic [3:0]            b_wstrb,
  input  logic [31:0]           b_rdata,
  input  logic                  b_rvalid,
`ifdef MRV32_PORTB_ARB_STATS_EN
  output logic [31:0]           stat_m0_grants,
  output logic [31:0]           stat_m1_grants,
  output logic [31:0]           stat_conflicts,
`endif
  output logic                  err_stray_rsp
);

  import mrv32_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             m0_is_rd, m1_is_rd;
  logic             m0_elig, m1_elig;
  logic             pop_ok, stray, can_push;
  logic             grant_any, push;
  arb_id_t          winner;
  arb_id_t          head_id;
  logic [0:0]       push_tag;
  logic [0:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  arb_id_t          rr_last_q, rr_last_d;
  logic             err_q, err_d;

  // Classify requests, decide eligibility and pick the round-robin winner.
  always_comb begin
    m0_is_rd  = (m0_wstrb == WSTRB_NONE);
    m1_is_rd  = (m1_wstrb == WSTRB_NONE);
    pop_ok    = b_rvalid & ~fifo_empty;
    stray     = b_rvalid & (fifo_count == '0);
    // A response popping this cycle frees a slot for a new read.
    can_push  = ~fifo_full | pop_ok;
    m0_elig   = m0_valid & (~m0_is_rd | can_push);
    m1_elig   = m1_valid & (~m1_is_rd | can_push);
    grant_any = m0_elig | m1_elig;
    if (m0_elig && m1_elig) begin
      winner = (rr_last_q == ARB_M0) ? ARB_M1 : ARB_M0;
    end else if (m0_elig) begin
      winner = ARB_M0;
    end else begin
      winner = ARB_M1;
    end
    push     = grant_any & ((winner == ARB_M0) ? m0_is_rd : m1_is_rd);
    push_tag = winner;
  end

  // Forward the winning request to Port B and route responses to the owner.
  always_comb begin
    b_valid  = grant_any;
    b_addr   = '0;
    b_wdata  = '0;
    b_wstrb  = '0;
    if (grant_any) begin
      if (winner == ARB_M0) begin
        b_addr  = m0_addr;
        b_wdata = m0_wdata;
        b_wstrb = m0_wstrb;
      end else begin
        b_addr  = m1_addr;
        b_wdata = m1_wdata;
        b_wstrb = m1_wstrb;
      end
    end
    m0_ready  = grant_any & (winner == ARB_M0);
    m1_ready  = grant_any & (winner == ARB_M1);
    head_id   = arb_id_t'(fifo_head);
    m0_rvalid = pop_ok & (head_id == ARB_M0);
    m1_rvalid = pop_ok & (head_id == ARB_M1);
    m0_rdata  = b_rdata;
    m1_rdata  = b_rdata;
  end

  mrv32_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_ok),
    .din   (push_tag),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Round-robin history and the sticky stray-response flag.
  always_comb begin
    rr_last_d = grant_any ? winner : rr_last_q;
    err_d     = err_q | stray;
  end

  // Arbiter state registers; rr_last starts at M1 so M0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= ARB_M1;
      err_q     <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

  assign err_stray_rsp = err_q;

`ifdef MRV32_PORTB_ARB_STATS_EN
  logic [31:0] stat_m0_q, stat_m0_d;
  logic [31:0] stat_m1_q, stat_m1_d;
  logic [31:0] stat_cf_q, stat_cf_d;

  // Wrapping event counters: grants per requester and two-way conflicts.
  always_comb begin
    stat_m0_d = stat_m0_q + {31'd0, m0_ready};
    stat_m1_d = stat_m1_q + {31'd0, m1_ready};
    stat_cf_d = stat_cf_q + {31'd0, (m0_elig & m1_elig)};
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_m0_q <= '0;
      stat_m1_q <= '0;
      stat_cf_q <= '0;
    end else begin
      stat_m0_q <= stat_m0_d;
      stat_m1_q <= stat_m1_d;
      stat_cf_q <= stat_cf_d;
    end
  end

  assign stat_m0_grants = stat_m0_q;
  assign stat_m1_grants = stat_m1_q;
  assign stat_conflicts = stat_cf_q;
`endif

endmodule

// File: tb/tb_mrv32_portb_arb.sv
// Bench for mrv32_portb_arb: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_mrv32_portb_arb;

  localparam int AW   = mrv32_pkg::ADDR_WIDTH;
  localparam int MAXO = mrv32_pkg::PORTB_ARB_MAX_OUTSTANDING;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_valid = 1'b0, m1_valid = 1'b0;
  logic          m0_ready, m1_ready;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_rvalid, m1_rvalid;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata;
  logic [3:0]    b_wstrb;
  logic [31:0]   b_rdata = '0;
  logic          b_rvalid = 1'b0;
  logic          err_stray_rsp;
`ifdef MRV32_PORTB_ARB_STATS_EN
  logic [31:0]   stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

  always #5 clk = ~clk;

  mrv32_portb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
`ifdef MRV32_PORTB_ARB_STATS_EN
    .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
    .stat_conflicts(stat_conflicts),
`endif
    .err_stray_rsp(err_stray_rsp)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          own_q[$];
  logic [31:0] exp0_q[$], exp1_q[$];
  int          mem_due[$];
  logic [31:0] mem_data[$];
  bit          rr_last = 1'b1;
  bit          err_m = 1'b0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  bit          last_g0, last_g1;
  logic        obs_m0_ready, obs_m1_ready;
  int          s_m0 = 0, s_m1 = 0, s_cf = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // One clock cycle: drive memory response, check DUT against model, advance model.
  task automatic cycle(input bit stray_inj);
    bit popv, stray, cp, e0, e1, g0, g1, any, rv0, rv1, rd, owner;
    logic [AW-1:0] ea;
    logic [31:0]   ew, ed;
    logic [3:0]    es;
    int            due;
    b_rvalid = 1'b0;
    b_rdata  = '0;
    if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
      b_rvalid = 1'b1;
      b_rdata  = mem_data.pop_front();
      void'(mem_due.pop_front());
    end else if (stray_inj) begin
      b_rvalid = 1'b1;
      b_rdata  = $urandom;
    end
    #1;
    popv  = b_rvalid && (own_q.size() != 0);
    stray = b_rvalid && (own_q.size() == 0);
    cp    = (own_q.size() < MAXO) || popv;
    e0    = m0_valid && (m0_wstrb != 4'h0 || cp);
    e1    = m1_valid && (m1_wstrb != 4'h0 || cp);
    g0    = e0 && (!e1 || rr_last);
    g1    = e1 && !g0;
    any   = g0 || g1;
    ea    = g0 ? m0_addr  : (g1 ? m1_addr  : '0);
    ew    = g0 ? m0_wdata : (g1 ? m1_wdata : '0);
    es    = g0 ? m0_wstrb : (g1 ? m1_wstrb : '0);
    rv0   = popv && (own_q[0] == 1'b0);
    rv1   = popv && (own_q[0] == 1'b1);
    chk("b_valid",   64'(b_valid),   64'(any));
    chk("m0_ready",  64'(m0_ready),  64'(g0));
    chk("m1_ready",  64'(m1_ready),  64'(g1));
    chk("b_addr",    64'(b_addr),    64'(ea));
    chk("b_wdata",   64'(b_wdata),   64'(ew));
    chk("b_wstrb",   64'(b_wstrb),   64'(es));
    chk("m0_rvalid", 64'(m0_rvalid), 64'(rv0));
    chk("m1_rvalid", 64'(m1_rvalid), 64'(rv1));
    chk("err",       64'(err_stray_rsp), 64'(err_m));
`ifdef MRV32_PORTB_ARB_STATS_EN
    chk("stat_m0", 64'(stat_m0_grants), 64'(s_m0));
    chk("stat_m1", 64'(stat_m1_grants), 64'(s_m1));
    chk("stat_cf", 64'(stat_conflicts), 64'(s_cf));
`endif
    if (popv) begin
      owner = own_q.pop_front();
      if (!owner) chk("m0_rdata", 64'(m0_rdata), 64'(exp0_q.pop_front()));
      else        chk("m1_rdata", 64'(m1_rdata), 64'(exp1_q.pop_front()));
    end
    if (stray) err_m = 1'b1;
    if (any) begin
      rr_last = g1;
      rd = (es == 4'h0);
      if (rd) begin
        own_q.push_back(g1);
        ed = mem_fn(ea);
        if (g1) exp1_q.push_back(ed);
        else    exp0_q.push_back(ed);
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        mem_due.push_back(due);
        mem_data.push_back(ed);
      end
    end
    s_m0 += int'(g0);
    s_m1 += int'(g1);
    s_cf += int'(e0 && e1);
    last_g0 = g0;
    last_g1 = g1;
    obs_m0_ready = m0_ready;
    obs_m1_ready = m1_ready;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    b_rvalid = 1'b0;
    b_rdata  = '0;
    #1;
    own_q.delete();
    exp0_q.delete();
    exp1_q.delete();
    rr_last = 1'b1;
    err_m   = 1'b0;
    s_m0 = 0; s_m1 = 0; s_cf = 0;
    last_g0 = 1'b0; last_g1 = 1'b0;
    chk("rst_b_valid",   64'(b_valid),       64'(0));
    chk("rst_m0_ready",  64'(m0_ready),      64'(0));
    chk("rst_m1_ready",  64'(m1_ready),      64'(0));
    chk("rst_m0_rvalid", 64'(m0_rvalid),     64'(0));
    chk("rst_m1_rvalid", 64'(m1_rvalid),     64'(0));
    chk("rst_b_addr",    64'(b_addr),        64'(0));
    chk("rst_b_wstrb",   64'(b_wstrb),       64'(0));
    chk("rst_err",       64'(err_stray_rsp), 64'(0));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_m0(input bit v, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic set_m1(input bit v, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  task automatic idle(input int n);
    set_m0(1'b0, '0, '0, 4'h0);
    set_m1(1'b0, '0, '0, 4'h0);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    bit got;
    int nacc;

    do_reset();

    // Lone M0 write passes through in the same cycle and occupies no slot.
    set_m0(1'b1, AW'('h10), 32'hDEADBEEF, 4'b1111);
    cycle(1'b0);
    chk("wr_m0_ready", 64'(obs_m0_ready), 64'(1));
    idle(2);

    // Both masters hold reads; single-cycle memory; grants alternate M0,M1,...
    do_reset();
    lat = 1;
    set_m0(1'b1, AW'('h100), '0, 4'h0);
    set_m1(1'b1, AW'('h200), '0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      chk("alt_m0_grant", 64'(obs_m0_ready), 64'((i % 2) == 0));
      chk("alt_m1_grant", 64'(obs_m1_ready), 64'((i % 2) == 1));
    end
    idle(3);

    // Three M1 reads with 3-cycle memory: third stalls until the first response.
    lat  = 3;
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      set_m1(1'b1, AW'('h300 + 4 * nacc), '0, 4'h0);
      cycle(1'b0);
      if (i == 2) chk("ld_third_stall",  64'(obs_m1_ready), 64'(0));
      if (i == 3) chk("ld_third_accept", 64'(obs_m1_ready), 64'(1));
      nacc += int'(obs_m1_ready);
    end
    idle(6);

    // FIFO full: M0 read stalls while M1 writes keep flowing.
    lat = 8;
    set_m0(1'b1, AW'('h400), '0, 4'h0);
    cycle(1'b0);
    set_m0(1'b1, AW'('h404), '0, 4'h0);
    cycle(1'b0);
    set_m0(1'b1, AW'('h408), '0, 4'h0);
    set_m1(1'b1, AW'('h500), 32'hCAFE0001, 4'b0011);
    cycle(1'b0);
    chk("full_m1_wr_ready", 64'(obs_m1_ready), 64'(1));
    chk("full_m0_stall",    64'(obs_m0_ready), 64'(0));
    set_m1(1'b1, AW'('h504), 32'hCAFE0002, 4'b1100);
    cycle(1'b0);
    chk("full_m1_wr2_ready", 64'(obs_m1_ready), 64'(1));
    set_m1(1'b0, '0, '0, 4'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(1'b0);
      got = obs_m0_ready;
    end
    chk("full_m0_eventual", 64'(got), 64'(1));
    idle(12);

    // Stray response, sticky flag, and reset with a read still in flight.
    cycle(1'b1);
    idle(1);
    chk("stray_err_set", 64'(err_stray_rsp), 64'(1));
    idle(3);
    chk("stray_err_sticky", 64'(err_stray_rsp), 64'(1));
    lat = 5;
    set_m0(1'b1, AW'('h600), '0, 4'h0);
    cycle(1'b0);
    idle(1);
    do_reset();
    chk("post_rst_err", 64'(err_stray_rsp), 64'(0));
    idle(8);
    chk("late_stray_err", 64'(err_stray_rsp), 64'(1));

`ifdef MRV32_PORTB_ARB_STATS_EN
    // Five conflicting write cycles.
    do_reset();
    set_m0(1'b1, AW'('h700), 32'h1, 4'hF);
    set_m1(1'b1, AW'('h800), 32'h2, 4'hF);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    idle(1);
    chk("stat_conflicts_5", 64'(stat_conflicts), 64'(5));
    chk("stat_sum_5", 64'(stat_m0_grants + stat_m1_grants), 64'(5));
    chk("stat_balance", 64'((stat_m0_grants > stat_m1_grants ? stat_m0_grants - stat_m1_grants
                                                              : stat_m1_grants - stat_m0_grants) <= 1),
        64'(1));
`endif

    // Random traffic; losers hold their request until granted.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!(m0_valid && !last_g0)) begin
        m0_valid = ($urandom_range(0, 9) < 6);
        m0_addr  = AW'($urandom) & ~AW'(3);
        m0_wdata = $urandom;
        m0_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (!(m1_valid && !last_g1)) begin
        m1_valid = ($urandom_range(0, 9) < 6);
        m1_addr  = AW'($urandom) & ~AW'(3);
        m1_wdata = $urandom;
        m1_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      lat = $urandom_range(1, 4);
      cycle(mem_due.size() == 0 && own_q.size() == 0 && $urandom_range(0, 49) == 0);
    end
    idle(12);
    chk("drain_m0", 64'(exp0_q.size()), 64'(0));
    chk("drain_m1", 64'(exp1_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrv32_portb_arb.md
Name: mrv32_portb_arb

Overview:
Two-requester arbiter sharing data-memory Port B (valid/rvalid protocol, in-order read responses) between the core LSU (M0) and the debug/program-loader master (M1).
- Arbitrates round-robin per request.
- Forwards the granted request to Port B in the same cycle.
- Tracks the owners of outstanding reads in an in-order tag FIFO and routes each b_rvalid/b_rdata back to the issuing requester.
- Sits between mrv32_lsu / debug master and the dual-port memory.

Parameters:
ADDR_WIDTH, mrv32_pkg::ADDR_WIDTH, Port B byte-address width
MAX_OUTSTANDING, 2, max reads in flight (tag FIFO depth, power of 2, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_valid  in  1  LSU request valid; held until m0_ready
m0_ready  out  1  LSU request accepted this cycle
m0_addr  in  ADDR_WIDTH  LSU byte address
m0_wdata  in  32  LSU store data (lane-aligned)
m0_wstrb  in  4  LSU byte strobes; 4'b0000 = read
m0_rdata  out  32  read data to LSU
m0_rvalid  out  1  read response pulse to LSU
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_rvalid  same as M0, for the debug/loader master
b_valid  out  1  Port B request
b_addr  out  ADDR_WIDTH  Port B address
b_wdata  out  32  Port B write data
b_wstrb  out  4  Port B strobes
b_rdata  in  32  Port B read data
b_rvalid  in  1  Port B read response
err_stray_rsp  out  1  sticky: b_rvalid received with no read outstanding

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset clears the tag FIFO (count=0, pointers=0), sets rr_last=M1 so M0 wins the first conflict, and clears err_stray_rsp.
  - All outputs are 0 during and after reset until requests arrive.
- Request classes:
  - Write: wstrb!=0; never occupies a FIFO slot.
  - Read: wstrb==0.
- Eligibility: mX_elig = mX_valid & (is_write | can_push).
  - can_push = (count < MAX_OUTSTANDING) | (b_rvalid & count!=0), i.e. a same-cycle pop frees a slot.
- Grant (combinational, 0-cycle latency):
  - Only one requester eligible: it wins.
  - Both eligible: the one not equal to rr_last wins.
  - rr_last updates to the winner on every grant.
- Request path:
  - b_valid = grant_any; b_addr/b_wdata/b_wstrb are muxed from the winner.
  - No grant: b_addr/b_wdata = 0, b_wstrb = 0.
  - mX_ready = grant to X. A loser holds its request unchanged (stable valid/payload until ready).
- Tag FIFO:
  - Granted read: pushes the winner ID (1 bit).
  - b_rvalid with count!=0: pops the head.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing (combinational):
  - mX_rvalid = b_rvalid & count!=0 & head==X.
  - m0_rdata = m1_rdata = b_rdata (qualified only by rvalid).
- Stray response: b_rvalid with count==0 sets err_stray_rsp (sticky until reset); the response is dropped and no mX_rvalid is raised.
- Full FIFO: pending reads stall (ready=0). Writes from either side continue to be granted.
- Reset mid-operation: in-flight reads are forgotten; their later responses are flagged stray.

Optional Feature:
MRV32_PORTB_ARB_STATS_EN
- Defined:
  - Adds outputs stat_m0_grants[31:0], stat_m1_grants[31:0] and stat_conflicts[31:0].
  - stat_conflicts counts cycles where both requesters were eligible.
  - All three are wrapping counters, reset to 0, and increment on the cycle of the event.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- mrv32_pkg:
  - WSTRB_NONE (already present).
  - New typedef arb_id_t (enum logic {ARB_M0, ARB_M1}).
  - PORTB_ARB_MAX_OUTSTANDING default constant.
- Sub-module mrv32_tag_fifo: parameterised DEPTH/WIDTH synchronous FIFO.
  - push/pop/full/empty/head/count.
  - Simultaneous push+pop allowed when full.

Test Plan:
- Only M0 write (addr=0x10, wdata=0xDEADBEEF, wstrb=4'b1111) -> same cycle b_valid=1, b_wstrb=4'b1111, m0_ready=1; FIFO count stays 0.
- M0 and M1 both hold reads for 4 cycles, memory answers in 1 cycle -> grants alternate M0,M1,M0,M1; each mX_rvalid matches its own address data (0x11111111 vs 0x22222222).
- MAX_OUTSTANDING=2, memory delays responses 3 cycles, M1 issues 3 reads -> third read stalls (m1_ready=0) until the first b_rvalid, then is accepted in that same cycle.
- FIFO full with M0 read pending and M1 write pending -> M1 write granted immediately; M0 stalls.
- b_rvalid with no outstanding read -> no mX_rvalid, err_stray_rsp=1 and remains 1; assert rst_n=0 mid-flight -> err clears, FIFO empties, the later response sets err again.
- With MRV32_PORTB_ARB_STATS_EN, 5 conflicting cycles -> stat_conflicts=5, stat_m0_grants + stat_m1_grants = 5 with a difference of at most 1.
